// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder with word RAM and an I/O window (console FIFO, status, timer)
// Ports: clk/rst (async active-high); addr/wdata/we from the core, rdata back combinationally;
// con_data/con_valid/con_ready drain the console FIFO; bad_access flags writes to unmapped addresses.
module data_mem_responder #(
  parameter int RAM_AW = 10,
  parameter int FIFO_AW = 3,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        we,
  output logic [31:0] con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        bad_access
);
  logic [31:0] ram [2**RAM_AW];
  logic [31:0] fifo [2**FIFO_AW];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0] count;
  logic [31:0] timer, stat;
  logic ovf, ram_hit, con_hit, stat_hit, timer_hit, full, empty, push_req, push, pop;
  assign ram_hit = addr[31:RAM_AW] == '0;
  assign con_hit = addr == IO_BASE;
  assign stat_hit = addr == IO_BASE + 32'd1;
  assign timer_hit = addr == IO_BASE + 32'd2;
  assign empty = count == '0;
  assign full = count[FIFO_AW];
  assign con_valid = !empty;
  assign con_data = fifo[rp];
  assign pop = con_valid && con_ready;
  assign push_req = we && con_hit;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign push = push_req && (!full || pop);
  assign stat = (32'(count) << 8) | {29'b0, ovf, full, empty};
  always_comb
    rdata = ram_hit ? ram[addr[RAM_AW-1:0]] : stat_hit ? stat : timer_hit ? timer : 32'b0;
  always_ff @(posedge clk) begin
    if (we && ram_hit) ram[addr[RAM_AW-1:0]] <= wdata;
    if (push) fifo[wp] <= wdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ovf <= 1'b0;
      timer <= '0;
      bad_access <= 1'b0;
    end else begin
      wp <= wp + FIFO_AW'(push);
      rp <= rp + FIFO_AW'(pop);
      count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      // a dropped push outranks a clear request
      ovf <= (push_req && !push) ? 1'b1 : (we && stat_hit && wdata[2]) ? 1'b0 : ovf;
      timer <= (we && timer_hit) ? wdata : timer + 32'd1;
      bad_access <= bad_access | (we && !ram_hit && !con_hit && !stat_hit && !timer_hit);
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table vectors plus a console scoreboard for data_mem_responder
module tb_data_mem_responder;
  localparam logic [31:0] CON = 32'hFFFF_FF00, STAT = 32'hFFFF_FF01, TIMER = 32'hFFFF_FF02;
  logic clk = 1'b0, rst, we, con_valid, con_ready, bad_access;
  logic [31:0] addr, wdata, rdata, con_data;
  int n_tests = 0, n_fail = 0;
  logic [31:0] sb [$];
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic w;
    logic chk;
    logic [31:0] exp;
    logic exp_bad;
  } vec_t;
  vec_t vecs [12];
  data_mem_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rdata(rdata), .we(we),
    .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready), .bad_access(bad_access)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    logic pop, acc;
    pop = sb.size() != 0 && con_ready;
    acc = we && addr == CON && (sb.size() < 8 || pop);
    chk("con_valid", {31'b0, con_valid}, {31'b0, sb.size() != 0});
    if (pop) begin
      chk("con_data", con_data, sb[0]);
      void'(sb.pop_front());
    end
    if (acc) sb.push_back(wdata);
    @(posedge clk);
    #1;
  endtask
  task automatic push_con(input logic [31:0] w);
    addr = CON;
    wdata = w;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask
  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask
  task automatic drain(input int n);
    int c = 0;
    con_ready = 1'b1;
    we = 1'b0;
    while (sb.size() != 0 && c < 20) begin
      tick();
      c++;
    end
    chk("drain_len", 32'(c), 32'(n));
    con_ready = 1'b0;
    chk("drain_end_valid", {31'b0, con_valid}, 32'b0);
  endtask
  initial begin
    vecs[0]  = '{32'd6, 32'h1111_1111, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{32'd5, 32'h0000_0005, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{32'd5, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0005, 1'b0};
    vecs[3]  = '{32'd5, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{32'd6, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 1'b0};
    vecs[5]  = '{32'h0000_8000, 32'h1234_5678, 1'b1, 1'b1, 32'h0, 1'b1};
    vecs[6]  = '{32'h0000_8000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    vecs[7]  = '{32'd5, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[8]  = '{STAT, 32'h0, 1'b0, 1'b1, 32'h1, 1'b1};
    vecs[9]  = '{CON, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    vecs[10] = '{32'hFFFF_FF03, 32'h5, 1'b1, 1'b1, 32'h0, 1'b1};
    vecs[11] = '{32'h0000_0400, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    rst = 1'b1;
    addr = '0;
    wdata = '0;
    we = 1'b0;
    con_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rd("rst_stat", STAT, 32'h1);
    rd("rst_timer", TIMER, 32'h0);
    chk("rst_valid", {31'b0, con_valid}, 32'b0);
    chk("rst_bad", {31'b0, bad_access}, 32'b0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rd("timer_10", TIMER, 32'd10);
    wdata = 32'hFFFF_FFFE;
    we = 1'b1;
    tick();
    we = 1'b0;
    rd("timer_ld0", TIMER, 32'hFFFF_FFFE);
    tick();
    rd("timer_ld1", TIMER, 32'hFFFF_FFFF);
    tick();
    rd("timer_wrap", TIMER, 32'h0);
    foreach (vecs[i]) begin
      addr = vecs[i].a;
      wdata = vecs[i].d;
      we = vecs[i].w;
      #1;
      if (vecs[i].chk) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
      tick();
      chk($sformatf("vec%0d_bad", i), {31'b0, bad_access}, {31'b0, vecs[i].exp_bad});
    end
    we = 1'b0;
    for (int i = 1; i <= 3; i++) push_con(32'(i));
    rd("fifo3_stat", STAT, 32'h300);
    drain(3);
    rd("fifo3_empty", STAT, 32'h1);
    for (int i = 0; i < 9; i++) push_con(32'(10 + i));
    rd("ovf_stat", STAT, 32'h806);
    addr = STAT;
    wdata = 32'h4;
    we = 1'b1;
    tick();
    we = 1'b0;
    rd("ovf_clr", STAT, 32'h802);
    con_ready = 1'b1;
    push_con(32'd99);
    con_ready = 1'b0;
    rd("full_pushpop", STAT, 32'h802);
    drain(8);
    rd("ovf_empty", STAT, 32'h1);
    push_con(32'd42);
    con_ready = 1'b1;
    push_con(32'd43);
    con_ready = 1'b0;
    rd("one_pushpop", STAT, 32'h100);
    chk("one_head", con_data, 32'd43);
    drain(1);
    for (int i = 0; i < 4; i++) push_con(32'(70 + i));
    con_ready = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, con_valid}, 32'b0);
    rd("arst_stat", STAT, 32'h1);
    rd("arst_timer", TIMER, 32'h0);
    chk("arst_bad", {31'b0, bad_access}, 32'b0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    con_ready = 1'b0;
    rd("post_stat", STAT, 32'h1);
    rd("post_timer", TIMER, 32'h0);
    rd("post_ram5", 32'd5, 32'hDEAD_BEEF);
    rd("post_ram6", 32'd6, 32'h1111_1111);
    chk("post_valid", {31'b0, con_valid}, 32'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
